// File: rtl/uart_cmd_master.sv
// UART command master: decodes host byte frames into 32-bit native-bus reads/writes
// and streams the response bytes back through the UART bridge transmitter.
module uart_cmd_master #(
  parameter int RX_TIMEOUT  = 20000,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_byte_rx_data,
  input  logic        i_byte_rx_valid,
  output logic [7:0]  o_byte_tx_data,
  output logic        o_byte_tx_valid,
  input  logic        i_byte_tx_busy,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int RXW = $clog2(RX_TIMEOUT + 1);
  localparam int MTW = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]     r_state;
  logic [7:0]     r_opcode;
  logic [1:0]     r_cnt;
  logic [31:0]    r_addr;
  logic [23:0]    r_wdata;
  logic [RXW-1:0] r_rx_timer;
  logic [MTW-1:0] r_mem_timer;
  logic [31:0]    r_reply;
  logic [2:0]     r_nreply;
  logic [1:0]     r_tx_idx;
  logic           r_tx_lag;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic           r_mem_valid;
  logic [31:0]    r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic [3:0]     r_mem_wstrb;
  logic           r_overrun;

  logic        w_accepting;
  logic        w_tx_ready;
  logic [31:0] w_addr_shift;
  logic [31:0] w_wdata_full;

  assign w_accepting  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  // The bridge raises busy one cycle late, so the cycle after a pulse never starts another
  assign w_tx_ready   = !r_tx_valid && !r_tx_lag && !i_byte_tx_busy;
  assign w_addr_shift = {i_byte_rx_data, r_addr[31:8]};
  assign w_wdata_full = {i_byte_rx_data, r_wdata};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rx_timer  <= '0;
      r_mem_timer <= '0;
      r_reply     <= '0;
      r_nreply    <= '0;
      r_tx_idx    <= '0;
      r_tx_lag    <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_tx_lag   <= r_tx_valid;
      if (i_byte_rx_valid && !w_accepting) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_rx_timer <= '0;
          r_cnt      <= '0;
          if (i_byte_rx_valid) begin
            r_opcode <= i_byte_rx_data;
            r_state  <= (i_byte_rx_data == 8'h01 || i_byte_rx_data == 8'h02) ? S_ADDR : S_ERR;
          end
        end
        S_ADDR, S_DATA: begin
          if (i_byte_rx_valid) begin
            r_rx_timer <= '0;
            r_cnt      <= r_cnt + 2'd1;
            if (r_state == S_ADDR) r_addr <= w_addr_shift;
            else                   r_wdata <= w_wdata_full[31:8];
            if (r_cnt == 2'd3) begin
              if (r_state == S_ADDR && r_opcode == 8'h01) begin
                r_state <= S_DATA;
              end else begin
                r_state     <= S_BUS;
                r_mem_valid <= 1'b1;
                r_mem_timer <= '0;
                if (r_state == S_ADDR) begin
                  r_mem_addr  <= w_addr_shift & 32'hFFFF_FFFC;
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= 4'h0;
                end else begin
                  r_mem_addr  <= r_addr & 32'hFFFF_FFFC;
                  r_mem_wdata <= w_wdata_full;
                  r_mem_wstrb <= 4'hF;
                end
              end
            end
          end else if (r_rx_timer == RXW'(RX_TIMEOUT - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_rx_timer <= r_rx_timer + RXW'(1);
          end
        end
        S_BUS: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_SEND;
            r_tx_idx    <= '0;
            if (r_opcode == 8'h01) begin
              r_reply  <= 32'h0000_00A5;
              r_nreply <= 3'd1;
            end else begin
              r_reply  <= i_mem_rdata;
              r_nreply <= 3'd4;
            end
          end else if (r_mem_timer == MTW'(MEM_TIMEOUT - 1)) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_ERR;
          end else begin
            r_mem_timer <= r_mem_timer + MTW'(1);
          end
        end
        S_ERR: begin
          r_reply  <= 32'h0000_00EE;
          r_nreply <= 3'd1;
          r_tx_idx <= '0;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_tx_ready) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_reply[{r_tx_idx, 3'b000} +: 8];
            r_tx_idx   <= r_tx_idx + 2'd1;
            if ({1'b0, r_tx_idx} == r_nreply - 3'd1) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_byte_tx_data  = r_tx_data;
  assign o_byte_tx_valid = r_tx_valid;
  assign o_mem_valid     = r_mem_valid;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_wstrb     = r_mem_wstrb;
  assign o_busy          = (r_state != S_IDLE);
  assign o_overrun       = r_overrun;

endmodule
